// File: rtl/sb_rx_fsm.sv
// Sideband RX controller: pattern detect, header/data framing,
// parity check and valid/ack delivery to the message decoder.
module sb_rx_fsm #(
  parameter logic [63:0] PATTERN_WORD  = 64'hAAAA_AAAA_AAAA_AAAA,
  parameter int          PATTERN_COUNT = 2,
  parameter int          DATA_TIMEOUT  = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_word_valid,
  input  logic [63:0] i_word,
  input  logic        i_pattern_mode,
  input  logic        i_msg_ack,
  output logic        o_pattern_detected,
  output logic        o_msg_valid,
  output logic [63:0] o_header,
  output logic [63:0] o_data,
  output logic        o_has_data,
  output logic        o_parity_err,
  output logic        o_overflow,
  output logic        o_timeout,
  output logic        o_busy
);

  localparam int PCW = $clog2(PATTERN_COUNT + 1);
  localparam int TCW = $clog2(DATA_TIMEOUT + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PAT  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DLV  = 2'd3;

  localparam logic [4:0] OPC_DATA = 5'b11011;

  logic [1:0]     state_q, state_d;
  logic [PCW-1:0] pat_cnt_q, pat_cnt_d;
  logic [TCW-1:0] to_cnt_q, to_cnt_d;
  logic [63:0]    header_q, header_d;
  logic [63:0]    data_q, data_d;
  logic           has_data_q, has_data_d;
  logic           parity_err_q, parity_err_d;
  logic           msg_valid_q, msg_valid_d;
  logic           overflow_q, overflow_d;
  logic           pat_det_q, pat_det_d;
  logic           timeout_q, timeout_d;
  logic           busy_q, busy_d;

  logic [PCW-1:0] pat_cnt_inc;
  logic           word_is_data;
  logic           cp_bad_word;
  logic           cp_bad_hdr;
  logic           dp_bad_word;

  // Next-state and datapath: one FSM owns every register.
  always_comb begin
    state_d      = state_q;
    pat_cnt_d    = pat_cnt_q;
    to_cnt_d     = to_cnt_q;
    header_d     = header_q;
    data_d       = data_q;
    has_data_d   = has_data_q;
    parity_err_d = parity_err_q;
    msg_valid_d  = msg_valid_q;
    overflow_d   = overflow_q;
    pat_det_d    = 1'b0;
    timeout_d    = 1'b0;

    pat_cnt_inc  = pat_cnt_q + 1'b1;
    word_is_data = (i_word[4:0] == OPC_DATA);
    cp_bad_word  = (^i_word[61:0]) != i_word[62];
    cp_bad_hdr   = (^header_q[61:0]) != header_q[62];
    dp_bad_word  = (^i_word) != header_q[63];

    case (state_q)
      S_IDLE: begin
        if (i_pattern_mode) begin
          state_d   = S_PAT;
          pat_cnt_d = '0;
        end else if (i_word_valid) begin
          header_d = i_word;
          data_d   = '0;
          to_cnt_d = '0;
          if (word_is_data) begin
            state_d = S_WAIT;
          end else begin
            state_d      = S_DLV;
            has_data_d   = 1'b0;
            parity_err_d = cp_bad_word | i_word[63];
            msg_valid_d  = 1'b1;
          end
        end
      end
      S_PAT: begin
        if (!i_pattern_mode) begin
          state_d   = S_IDLE;
          pat_cnt_d = '0;
        end else if (i_word_valid) begin
          if (i_word == PATTERN_WORD) begin
            if (pat_cnt_inc == PCW'(PATTERN_COUNT)) begin
              pat_det_d = 1'b1;
              pat_cnt_d = '0;
            end else begin
              pat_cnt_d = pat_cnt_inc;
            end
          end else begin
            pat_cnt_d = '0;
          end
        end
      end
      S_WAIT: begin
        if (i_word_valid) begin
          data_d       = i_word;
          has_data_d   = 1'b1;
          parity_err_d = cp_bad_hdr | dp_bad_word;
          msg_valid_d  = 1'b1;
          to_cnt_d     = '0;
          state_d      = S_DLV;
        end else if (to_cnt_q == TCW'(DATA_TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          header_d  = '0;
          to_cnt_d  = '0;
          state_d   = S_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      S_DLV: begin
        if (i_word_valid) begin
          overflow_d = 1'b1;
        end
        if (i_msg_ack) begin
          msg_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= S_IDLE;
      pat_cnt_q    <= '0;
      to_cnt_q     <= '0;
      header_q     <= '0;
      data_q       <= '0;
      has_data_q   <= 1'b0;
      parity_err_q <= 1'b0;
      msg_valid_q  <= 1'b0;
      overflow_q   <= 1'b0;
      pat_det_q    <= 1'b0;
      timeout_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pat_cnt_q    <= pat_cnt_d;
      to_cnt_q     <= to_cnt_d;
      header_q     <= header_d;
      data_q       <= data_d;
      has_data_q   <= has_data_d;
      parity_err_q <= parity_err_d;
      msg_valid_q  <= msg_valid_d;
      overflow_q   <= overflow_d;
      pat_det_q    <= pat_det_d;
      timeout_q    <= timeout_d;
      busy_q       <= busy_d;
    end
  end

  assign o_pattern_detected = pat_det_q;
  assign o_msg_valid        = msg_valid_q;
  assign o_header           = header_q;
  assign o_data             = data_q;
  assign o_has_data         = has_data_q;
  assign o_parity_err       = parity_err_q;
  assign o_overflow         = overflow_q;
  assign o_timeout          = timeout_q;
  assign o_busy             = busy_q;

endmodule

// File: tb/tb_sb_rx_fsm.sv
// Bench for sb_rx_fsm: vector table, corner sequences,
// and random traffic against a transaction-level model.
module tb_sb_rx_fsm;

  localparam logic [63:0] PAT = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam int PC = 2;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        wv;
  logic [63:0] w;
  logic        pm;
  logic        ack;
  logic        pd, mv, hd, pe, ovf, tout, busy;
  logic [63:0] hdr, dat;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sb_rx_fsm #(
    .PATTERN_WORD (PAT),
    .PATTERN_COUNT(PC),
    .DATA_TIMEOUT (TO)
  ) dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_word_valid      (wv),
    .i_word            (w),
    .i_pattern_mode    (pm),
    .i_msg_ack         (ack),
    .o_pattern_detected(pd),
    .o_msg_valid       (mv),
    .o_header          (hdr),
    .o_data            (dat),
    .o_has_data        (hd),
    .o_parity_err      (pe),
    .o_overflow        (ovf),
    .o_timeout         (tout),
    .o_busy            (busy)
  );

  typedef struct {
    logic        v;
    logic [63:0] w;
    logic        ack;
    logic        e_mv;
    logic        e_hd;
    logic        e_pe;
    logic        e_busy;
    logic [63:0] e_data;
  } vec_t;

  vec_t vec[16];

  task automatic chk(input string nm, input logic [63:0] a,
                     input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, a, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    wv = 1'b0; w = '0; ack = 1'b0;
  endtask

  function automatic logic [63:0] mkh(input logic [63:0] b,
                                      input bit flip, input bit dp);
    logic [63:0] h;
    h = b;
    h[62] = (^b[61:0]) ^ flip;
    h[63] = dp;
    return h;
  endfunction

  function automatic vec_t mk(input logic v, input logic [63:0] wd,
                              input logic a, input logic emv,
                              input logic ehd, input logic epe,
                              input logic eb, input logic [63:0] ed);
    vec_t r;
    r.v = v; r.w = wd; r.ack = a; r.e_mv = emv;
    r.e_hd = ehd; r.e_pe = epe; r.e_busy = eb; r.e_data = ed;
    return r;
  endfunction

  // Model: parity by counting ones, not by the xor reduction.
  function automatic bit par(input logic [63:0] x, input int n);
    int c = 0;
    for (int i = 0; i < n; i++) c += int'(x[i]);
    return c[0];
  endfunction

  bit          m_pat, m_wait, m_pres, m_ovf, m_pd, m_to;
  int          m_age, m_match;
  logic [63:0] m_hdr, m_data;
  bit          m_hasd, m_perr;

  task automatic m_reset();
    m_pat = 0; m_wait = 0; m_pres = 0; m_ovf = 0;
    m_pd = 0; m_to = 0; m_age = 0; m_match = 0;
    m_hdr = '0; m_data = '0; m_hasd = 0; m_perr = 0;
  endtask

  function automatic bit m_err(input logic [63:0] h,
                               input logic [63:0] d, input bit hasd);
    bit cp, dp;
    cp = par(h, 62) != h[62];
    dp = hasd ? (par(d, 64) != h[63]) : (h[63] != 1'b0);
    return cp || dp;
  endfunction

  task automatic m_step();
    m_pd = 0;
    m_to = 0;
    if (m_pres) begin
      if (wv) m_ovf = 1;
      if (ack) m_pres = 0;
    end else if (m_wait) begin
      if (wv) begin
        m_data = w; m_hasd = 1;
        m_perr = m_err(m_hdr, m_data, 1);
        m_wait = 0; m_pres = 1;
      end else if (m_age + 1 == TO) begin
        m_to = 1; m_wait = 0;
      end else begin
        m_age++;
      end
    end else if (m_pat) begin
      if (!pm) begin
        m_pat = 0; m_match = 0;
      end else if (wv) begin
        if (w == PAT) begin
          m_match++;
          if (m_match == PC) begin
            m_pd = 1; m_match = 0;
          end
        end else begin
          m_match = 0;
        end
      end
    end else begin
      if (pm) begin
        m_pat = 1; m_match = 0;
      end else if (wv) begin
        m_hdr = w; m_data = '0; m_age = 0;
        if (w[4:0] == 5'b11011) begin
          m_wait = 1;
        end else begin
          m_hasd = 0;
          m_perr = m_err(w, '0, 0);
          m_pres = 1;
        end
      end
    end
  endtask

  task automatic m_cmp();
    chk("r_mv", mv, m_pres);
    chk("r_pd", pd, m_pd);
    chk("r_to", tout, m_to);
    chk("r_ovf", ovf, m_ovf);
    chk("r_busy", busy, m_pat | m_wait | m_pres);
    if (m_pres) begin
      chk("r_hdr", hdr, m_hdr);
      chk("r_data", dat, m_data);
      chk("r_hd", hd, m_hasd);
      chk("r_pe", pe, m_perr);
    end
  endtask

  logic [63:0] h1, h1dp, hd1, hdb, d1;

  initial begin
    h1   = mkh(64'h0000_1234_5678_0012, 0, 0);
    h1dp = mkh(64'h0000_1234_5678_0012, 0, 1);
    hd1  = mkh(64'h0000_00AB_CDEF_001B, 0, 0);
    hdb  = mkh(64'h0000_00AB_CDEF_001B, 1, 0);
    d1   = 64'h0123_4567_89AB_CDEF;

    vec[0]  = mk(1, h1,   0, 1, 0, 0, 1, 0);
    vec[1]  = mk(0, 0,    0, 1, 0, 0, 1, 0);
    vec[2]  = mk(0, 0,    0, 1, 0, 0, 1, 0);
    vec[3]  = mk(0, 0,    1, 0, 0, 0, 0, 0);
    vec[4]  = mk(1, hd1,  0, 0, 0, 0, 1, 0);
    vec[5]  = mk(0, 0,    0, 0, 0, 0, 1, 0);
    vec[6]  = mk(0, 0,    0, 0, 0, 0, 1, 0);
    vec[7]  = mk(1, d1,   0, 1, 1, 0, 1, d1);
    vec[8]  = mk(0, 0,    1, 0, 0, 0, 0, 0);
    vec[9]  = mk(1, hdb,  0, 0, 0, 0, 1, 0);
    vec[10] = mk(1, d1,   0, 1, 1, 1, 1, d1);
    vec[11] = mk(0, 0,    1, 0, 0, 0, 0, 0);
    vec[12] = mk(1, h1dp, 0, 1, 0, 1, 1, 0);
    vec[13] = mk(0, 0,    1, 0, 0, 0, 0, 0);
    vec[14] = mk(1, h1,   0, 1, 0, 0, 1, 0);
    vec[15] = mk(0, 0,    1, 0, 0, 0, 0, 0);

    rst = 1'b1; pm = 1'b0;
    idle_in();
    tick(); tick();
    chk("rst_pd", pd, 0);   chk("rst_mv", mv, 0);
    chk("rst_hdr", hdr, 0); chk("rst_data", dat, 0);
    chk("rst_hd", hd, 0);   chk("rst_pe", pe, 0);
    chk("rst_ovf", ovf, 0); chk("rst_to", tout, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 16; i++) begin
      wv = vec[i].v; w = vec[i].w; ack = vec[i].ack;
      tick();
      chk($sformatf("v%0d_mv", i), mv, vec[i].e_mv);
      chk($sformatf("v%0d_busy", i), busy, vec[i].e_busy);
      if (vec[i].e_mv) begin
        chk($sformatf("v%0d_hd", i), hd, vec[i].e_hd);
        chk($sformatf("v%0d_pe", i), pe, vec[i].e_pe);
        chk($sformatf("v%0d_data", i), dat, vec[i].e_data);
      end
    end
    idle_in();
    tick();

    begin
      logic [63:0] pw[4];
      logic        ep[4];
      pw[0] = PAT; pw[1] = 64'h5555_5555_5555_5555;
      pw[2] = PAT; pw[3] = PAT;
      ep[0] = 0; ep[1] = 0; ep[2] = 0; ep[3] = 1;
      pm = 1'b1;
      tick();
      chk("pat_busy", busy, 1);
      for (int i = 0; i < 4; i++) begin
        wv = 1'b1; w = pw[i];
        tick();
        chk($sformatf("pat_pd%0d", i), pd, ep[i]);
        chk($sformatf("pat_mv%0d", i), mv, 0);
      end
      idle_in();
      tick();
      chk("pat_pd_end", pd, 0);
      pm = 1'b0;
      tick();
      chk("pat_exit_busy", busy, 0);
    end

    wv = 1'b1; w = hd1;
    tick();
    idle_in();
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk($sformatf("to_pulse%0d", k), tout, (k == 4));
      chk($sformatf("to_busy%0d", k), busy, (k < 4));
      chk($sformatf("to_mv%0d", k), mv, 0);
    end
    wv = 1'b1; w = h1;
    tick();
    chk("to_next_mv", mv, 1);
    chk("to_next_hdr", hdr, h1);
    idle_in(); ack = 1'b1;
    tick();
    idle_in();

    wv = 1'b1; w = h1;
    tick();
    wv = 1'b1; w = hd1;
    tick();
    chk("ovf_set", ovf, 1);
    chk("ovf_hdr", hdr, h1);
    chk("ovf_mv", mv, 1);
    wv = 1'b1; w = hd1; ack = 1'b1;
    tick();
    chk("ovf_ack_mv", mv, 0);
    chk("ovf_ack_busy", busy, 0);
    idle_in();
    tick(); tick();
    chk("ovf_sticky", ovf, 1);

    wv = 1'b1; w = hd1;
    tick();
    idle_in();
    tick();
    chk("rmid_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("rmid_busy0", busy, 0);
    chk("rmid_ovf0", ovf, 0);
    chk("rmid_hdr0", hdr, 0);
    tick();
    rst = 1'b0;
    wv = 1'b1; w = d1;
    tick();
    chk("rmid_mv", mv, 1);
    chk("rmid_hdr", hdr, d1);
    chk("rmid_hd", hd, 0);
    chk("rmid_data", dat, 0);
    chk("rmid_pe", pe, 0);
    idle_in(); ack = 1'b1;
    tick();
    chk("rmid_ack", mv, 0);
    idle_in();

    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_reset();
    pm = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 700 == 699) begin
        idle_in();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_reset();
      end else begin
        int sel;
        if ($urandom_range(39) == 0) pm = ~pm;
        wv  = ($urandom_range(9) < 4);
        ack = ($urandom_range(9) < 3);
        sel = $urandom_range(2);
        w   = {$urandom, $urandom};
        if (sel == 0) w = PAT;
        else if (sel == 1) w[4:0] = 5'b11011;
        m_step();
        tick();
        m_cmp();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
